// File: rtl/mem_ctrl_if.sv
// Cache<->memory byte-serial bus bundle: dcache/icache request ports, acks and RAM/IO pins.
// The controller takes the slave view; the requester/RAM side takes the master view.
interface mem_ctrl_if;
    logic        d_get_en;
    logic        d_write_mode;
    logic [17:0] d_addr;
    logic [7:0]  d_data;
    logic        d_out_en;
    logic [7:0]  d_content;
    logic        i_get_en;
    logic [17:0] i_addr;
    logic        i_out_en;
    logic [7:0]  i_content;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [17:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  d_get_en, d_write_mode, d_addr, d_data,
        input  i_get_en, i_addr,
        input  io_buffer_full, mem_din,
        output d_out_en, d_content, i_out_en, i_content,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output d_get_en, d_write_mode, d_addr, d_data,
        output i_get_en, i_addr,
        output io_buffer_full, mem_din,
        input  d_out_en, d_content, i_out_en, i_content,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates dcache (priority) and icache onto the single-port byte RAM/IO bus.
// Optional MEMCTRL_FAIR_EN forces an icache grant after STARVE_LIMIT back-to-back dcache grants.
module mem_ctrl
`ifdef MEMCTRL_FAIR_EN
#(
    parameter int STARVE_LIMIT = 8
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
    logic d_io_s;
    logic d_blocked_s;
    logic force_i_s;
    logic grant_d_s;
    logic grant_i_s;
    logic io_bubble_s;

    logic iss_valid_r;
    logic iss_port_d_r;
    logic iss_io_r;
    logic iss_write_r;

    assign d_io_s      = (bus.d_addr[17:16] == 2'b11);
    assign d_blocked_s = bus.d_write_mode & d_io_s & bus.io_buffer_full;
    // The cycle after any IO issue is dead so a still-held IO request is never replayed.
    assign io_bubble_s = iss_valid_r & iss_io_r;

`ifdef MEMCTRL_FAIR_EN
    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] fair_cnt_r;

    assign force_i_s = bus.i_get_en & (fair_cnt_r == CNT_MAX);

    // Count consecutive dcache grants that kept a waiting icache out.
    always_ff @(posedge clk) begin
        if (rst) begin
            fair_cnt_r <= '0;
        end else if (grant_i_s || !bus.i_get_en) begin
            fair_cnt_r <= '0;
        end else if (grant_d_s && (fair_cnt_r != CNT_MAX)) begin
            fair_cnt_r <= fair_cnt_r + CNT_ONE;
        end else begin
            fair_cnt_r <= fair_cnt_r;
        end
    end
`else
    assign force_i_s = 1'b0;
`endif

    // Grant selection for this cycle.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (rst || io_bubble_s) begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end else if (force_i_s) begin
            grant_i_s = 1'b1;
        end else if (bus.d_get_en && !d_blocked_s) begin
            grant_d_s = 1'b1;
        end else if (bus.i_get_en) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Drive the RAM/IO pins from the granted port.
    always_comb begin
        bus.mem_a    = 18'h00000;
        bus.mem_dout = 8'h00;
        bus.mem_wr   = 1'b0;
        if (grant_d_s) begin
            bus.mem_a    = bus.d_addr;
            bus.mem_dout = bus.d_data;
            bus.mem_wr   = bus.d_write_mode;
        end else if (grant_i_s) begin
            bus.mem_a    = bus.i_addr;
            bus.mem_dout = 8'h00;
            bus.mem_wr   = 1'b0;
        end else begin
            bus.mem_a    = 18'h00000;
            bus.mem_dout = 8'h00;
            bus.mem_wr   = 1'b0;
        end
    end

    // Issue register: remembers what was put on the bus so it can be acked next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_r  <= 1'b0;
            iss_port_d_r <= 1'b0;
            iss_io_r     <= 1'b0;
            iss_write_r  <= 1'b0;
        end else begin
            iss_valid_r  <= grant_d_s | grant_i_s;
            iss_port_d_r <= grant_d_s;
            iss_io_r     <= grant_d_s & d_io_s;
            iss_write_r  <= grant_d_s & bus.d_write_mode;
        end
    end

    assign bus.d_out_en  = iss_valid_r & iss_port_d_r;
    assign bus.i_out_en  = iss_valid_r & ~iss_port_d_r;
    assign bus.d_content = (bus.d_out_en & ~iss_write_r) ? bus.mem_din : 8'h00;
    assign bus.i_content = bus.i_out_en ? bus.mem_din : 8'h00;
endmodule
